// File: rtl/nn_pkg.sv
// Shared definitions for the fully-connected layer datapath: layer codes,
// engine states and per-layer geometry helpers reused by controller/buffers.
package nn_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int FRAC_DEF   = 8;

   typedef enum logic [1:0] {
      LAYER_H1   = 2'd0,
      LAYER_H2   = 2'd1,
      LAYER_OUT  = 2'd2,
      LAYER_NONE = 2'd3
   } layer_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BIAS  = 3'd1,
      ST_MAC   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   // Address width for a memory of x entries, never narrower than 1 bit.
   function automatic int clog2w(input int x);
      int r;
      r = $clog2(x);
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Number of inputs (K) feeding each neuron of layer l.
   function automatic int layer_k(input logic [1:0] l, input int in_s, input int h1_s,
                                  input int h2_s, input int out_s);
      case (l)
         LAYER_H1: return in_s;
         LAYER_H2: return h1_s;
         default:  return (out_s > 0) ? h2_s : h2_s;
      endcase
   endfunction

   // Number of neurons (N) in layer l.
   function automatic int layer_n(input logic [1:0] l, input int h1_s, input int h2_s,
                                  input int out_s);
      case (l)
         LAYER_H1: return h1_s;
         LAYER_H2: return h2_s;
         default:  return out_s;
      endcase
   endfunction

   // First weight address of layer l; weights are stored neuron-major.
   function automatic int w_base(input logic [1:0] l, input int in_s, input int h1_s,
                                 input int h2_s);
      case (l)
         LAYER_H1: return 0;
         LAYER_H2: return in_s * h1_s;
         default:  return in_s * h1_s + h1_s * h2_s;
      endcase
   endfunction

   // First bias address of layer l.
   function automatic int b_base(input logic [1:0] l, input int h1_s, input int h2_s);
      case (l)
         LAYER_H1: return 0;
         LAYER_H2: return h1_s;
         default:  return h1_s + h2_s;
      endcase
   endfunction

endpackage

// File: rtl/neuron_layer_engine_if.sv
// Bundle between the layer engine and its controller / ROMs / result buffer.
// Protocol: start_neuron is a level request sampled only while the engine is
// idle; the engine answers with busy for the whole layer and a single-cycle
// calculation_done. ROM reads have a fixed 1-cycle latency (data valid the
// cycle after the address), and res_we is a 1-cycle write strobe with no
// backpressure.
interface neuron_layer_engine_if #(
   parameter int DATA_W = 16,
   parameter int ACT_AW = 6,
   parameter int W_AW   = 12,
   parameter int B_AW   = 7,
   parameter int RES_AW = 5
);
   logic              start_neuron;
   logic [1:0]        layer;
   logic [ACT_AW-1:0] act_addr;
   logic [DATA_W-1:0] act_data;
   logic [W_AW-1:0]   w_addr;
   logic [DATA_W-1:0] w_data;
   logic [B_AW-1:0]   b_addr;
   logic [DATA_W-1:0] b_data;
   logic              res_we;
   logic [RES_AW-1:0] res_addr;
   logic [DATA_W-1:0] res_data;
   logic [1:0]        res_layer;
   logic              busy;
   logic              calculation_done;

   modport master (
      output start_neuron, layer, act_data, w_data, b_data,
      input  act_addr, w_addr, b_addr, res_we, res_addr, res_data, res_layer,
             busy, calculation_done
   );

   modport slave (
      input  start_neuron, layer, act_data, w_data, b_data,
      output act_addr, w_addr, b_addr, res_we, res_addr, res_data, res_layer,
             busy, calculation_done
   );
endinterface

// File: rtl/nn_mac_act.sv
// Accumulator for one neuron (bias load + signed MAC) followed by the
// combinational output stage: arithmetic shift, optional ReLU, saturation.
module nn_mac_act #(
   parameter int DATA_W = 16,
   parameter int FRAC   = 8,
   parameter int ACC_W  = 40
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_bias,
   input  logic                     accumulate,
   input  logic                     relu,
   input  logic signed [DATA_W-1:0] b_data,
   input  logic signed [DATA_W-1:0] act_data,
   input  logic signed [DATA_W-1:0] w_data,
   output logic        [DATA_W-1:0] result
);
   localparam int PROD_W = 2 * DATA_W;

   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   logic signed [PROD_W-1:0] act_ext;
   logic signed [PROD_W-1:0] w_ext;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  bias_ext;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  shifted;
   logic signed [ACC_W-1:0]  limited;

   // Operands are widened first so the product is the full signed result.
   assign act_ext  = {{DATA_W{act_data[DATA_W-1]}}, act_data};
   assign w_ext    = {{DATA_W{w_data[DATA_W-1]}}, w_data};
   assign prod     = act_ext * w_ext;
   assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
   // Bias is aligned to the product's binary point (2*FRAC fraction bits).
   assign bias_ext = {{(ACC_W-DATA_W-FRAC){b_data[DATA_W-1]}}, b_data, {FRAC{1'b0}}};

   // Accumulator: bias load starts a neuron, accumulate adds one product.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (load_bias) begin
         acc <= bias_ext;
      end else if (accumulate) begin
         acc <= acc + prod_ext;
      end
   end

   // Output stage: rescale, clamp negatives for hidden layers, saturate.
   always_comb begin
      shifted = acc >>> FRAC;
      limited = shifted;
      if (relu && shifted[ACC_W-1]) begin
         limited = '0;
      end
      if (limited > SAT_MAX) begin
         limited = SAT_MAX;
      end else if (limited < SAT_MIN) begin
         limited = SAT_MIN;
      end
      result = limited[DATA_W-1:0];
   end
endmodule

// File: rtl/neuron_layer_engine.sv
// Layer sequencer: walks every neuron of the selected layer through
// BIAS -> MAC (K cycles) -> DRAIN -> WRITE and pulses calculation_done once.
// Arithmetic lives in nn_mac_act; this file owns the FSM and counters.
module neuron_layer_engine
   import nn_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int FRAC     = FRAC_DEF,
   parameter int ACC_W    = 40,
   parameter int IN_SIZE  = 62,
   parameter int H1_SIZE  = 30,
   parameter int H2_SIZE  = 30,
   parameter int OUT_SIZE = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   neuron_layer_engine_if.slave  bus,
   output state_t                state_dbg
);
   localparam int ACT_AW = clog2w(max3(IN_SIZE, H1_SIZE, H2_SIZE));
   localparam int W_AW   = clog2w(IN_SIZE * H1_SIZE + H1_SIZE * H2_SIZE + H2_SIZE * OUT_SIZE);
   localparam int B_AW   = clog2w(H1_SIZE + H2_SIZE + OUT_SIZE);
   localparam int RES_AW = clog2w(max3(H1_SIZE, H2_SIZE, OUT_SIZE));

   state_t              state;
   logic [1:0]          layer_q;
   logic [RES_AW-1:0]   n_cnt;
   logic [ACT_AW-1:0]   k_cnt;
   logic [W_AW-1:0]     w_ptr;
   logic [ACT_AW-1:0]   act_addr_q;
   logic [W_AW-1:0]     w_addr_q;
   logic [B_AW-1:0]     b_addr_q;
   logic                res_we_q;
   logic [RES_AW-1:0]   res_addr_q;
   logic                busy_q;
   logic                done_q;

   logic [ACT_AW-1:0]   k_last;
   logic [RES_AW-1:0]   n_last;
   logic [B_AW-1:0]     b_base_cur;
   logic                load_bias;
   logic                accumulate;
   logic                relu;
   logic [DATA_W-1:0]   result;

   // Geometry of the latched layer.
   assign k_last     = ACT_AW'(layer_k(layer_q, IN_SIZE, H1_SIZE, H2_SIZE, OUT_SIZE) - 1);
   assign n_last     = RES_AW'(layer_n(layer_q, H1_SIZE, H2_SIZE, OUT_SIZE) - 1);
   assign b_base_cur = B_AW'(b_base(layer_q, H1_SIZE, H2_SIZE));

   // The first MAC cycle sees the bias; later MAC cycles and DRAIN see products.
   assign load_bias  = (state == ST_MAC) && (k_cnt == '0);
   assign accumulate = ((state == ST_MAC) && (k_cnt != '0)) || (state == ST_DRAIN);
   assign relu       = (layer_q != LAYER_OUT);

   // Sequencer: state, counters, weight pointer and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         layer_q    <= '0;
         n_cnt      <= '0;
         k_cnt      <= '0;
         w_ptr      <= '0;
         act_addr_q <= '0;
         w_addr_q   <= '0;
         b_addr_q   <= '0;
         res_we_q   <= 1'b0;
         res_addr_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         res_we_q <= 1'b0;
         done_q   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start_neuron && (bus.layer != LAYER_NONE)) begin
                  layer_q  <= bus.layer;
                  n_cnt    <= '0;
                  w_ptr    <= W_AW'(w_base(bus.layer, IN_SIZE, H1_SIZE, H2_SIZE));
                  b_addr_q <= B_AW'(b_base(bus.layer, H1_SIZE, H2_SIZE));
                  busy_q   <= 1'b1;
                  state    <= ST_BIAS;
               end
            end
            ST_BIAS: begin
               b_addr_q   <= '0;
               k_cnt      <= '0;
               act_addr_q <= '0;
               w_addr_q   <= w_ptr;
               state      <= ST_MAC;
            end
            ST_MAC: begin
               // w_ptr always ends one past the neuron, i.e. at the next neuron's row.
               w_ptr <= w_ptr + 1'b1;
               if (k_cnt == k_last) begin
                  act_addr_q <= '0;
                  w_addr_q   <= '0;
                  state      <= ST_DRAIN;
               end else begin
                  k_cnt      <= k_cnt + 1'b1;
                  act_addr_q <= k_cnt + 1'b1;
                  w_addr_q   <= w_ptr + 1'b1;
               end
            end
            ST_DRAIN: begin
               res_we_q   <= 1'b1;
               res_addr_q <= n_cnt;
               state      <= ST_WRITE;
            end
            ST_WRITE: begin
               res_addr_q <= '0;
               if (n_cnt == n_last) begin
                  done_q <= 1'b1;
                  state  <= ST_DONE;
               end else begin
                  n_cnt    <= n_cnt + 1'b1;
                  b_addr_q <= b_base_cur + B_AW'(n_cnt) + 1'b1;
                  state    <= ST_BIAS;
               end
            end
            ST_DONE: begin
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   nn_mac_act #(
      .DATA_W (DATA_W),
      .FRAC   (FRAC),
      .ACC_W  (ACC_W)
   ) u_mac_act (
      .clk        (clk),
      .rst        (rst),
      .load_bias  (load_bias),
      .accumulate (accumulate),
      .relu       (relu),
      .b_data     (bus.b_data),
      .act_data   (bus.act_data),
      .w_data     (bus.w_data),
      .result     (result)
   );

   assign bus.act_addr         = act_addr_q;
   assign bus.w_addr           = w_addr_q;
   assign bus.b_addr           = b_addr_q;
   assign bus.res_we           = res_we_q;
   assign bus.res_addr         = res_addr_q;
   assign bus.res_data         = result;
   assign bus.res_layer        = layer_q;
   assign bus.busy             = busy_q;
   assign bus.calculation_done = done_q;
   assign state_dbg            = state;
endmodule

// File: tb/tb_neuron_layer_engine.sv
// Directed bench for neuron_layer_engine with a small 4-2-2-2 network and
// 1-cycle ROM models. Every cycle's outputs are logged so timing can be
// checked against cycle offsets from the accept cycle.
module tb_neuron_layer_engine;
   import nn_pkg::*;

   localparam int T_DATA_W = 16;
   localparam int T_FRAC   = 8;
   localparam int T_ACC_W  = 40;
   localparam int T_IN     = 4;
   localparam int T_H1     = 2;
   localparam int T_H2     = 2;
   localparam int T_OUT    = 2;
   localparam int T_ACT_AW = clog2w(max3(T_IN, T_H1, T_H2));
   localparam int T_W_AW   = clog2w(T_IN * T_H1 + T_H1 * T_H2 + T_H2 * T_OUT);
   localparam int T_B_AW   = clog2w(T_H1 + T_H2 + T_OUT);
   localparam int T_RES_AW = clog2w(max3(T_H1, T_H2, T_OUT));
   localparam int LOGN     = 2048;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   int     cyc = 0;
   int     checks = 0;
   int     failures = 0;
   state_t state_dbg;

   logic [15:0] act_mem [4];
   logic [15:0] w_mem   [16];
   logic [15:0] b_mem   [8];

   logic        lg_we   [LOGN];
   logic [15:0] lg_rd   [LOGN];
   logic        lg_ra   [LOGN];
   logic [1:0]  lg_rl   [LOGN];
   logic [3:0]  lg_wa   [LOGN];
   logic [2:0]  lg_ba   [LOGN];
   logic        lg_done [LOGN];
   logic        lg_busy [LOGN];

   neuron_layer_engine_if #(
      .DATA_W (T_DATA_W),
      .ACT_AW (T_ACT_AW),
      .W_AW   (T_W_AW),
      .B_AW   (T_B_AW),
      .RES_AW (T_RES_AW)
   ) bus ();

   neuron_layer_engine #(
      .DATA_W   (T_DATA_W),
      .FRAC     (T_FRAC),
      .ACC_W    (T_ACC_W),
      .IN_SIZE  (T_IN),
      .H1_SIZE  (T_H1),
      .H2_SIZE  (T_H2),
      .OUT_SIZE (T_OUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ROM models with 1-cycle read latency.
   always @(posedge clk) begin
      bus.act_data <= act_mem[bus.act_addr];
      bus.w_data   <= w_mem[bus.w_addr];
      bus.b_data   <= b_mem[bus.b_addr];
   end

   // Per-cycle output log, sampled mid-cycle.
   always @(negedge clk) begin
      if (cyc < LOGN) begin
         lg_we[cyc]   <= bus.res_we;
         lg_rd[cyc]   <= bus.res_data;
         lg_ra[cyc]   <= bus.res_addr;
         lg_rl[cyc]   <= bus.res_layer;
         lg_wa[cyc]   <= bus.w_addr;
         lg_ba[cyc]   <= bus.b_addr;
         lg_done[cyc] <= bus.calculation_done;
         lg_busy[cyc] <= bus.busy;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic fill(input logic [15:0] a, input logic [15:0] w, input logic [15:0] b);
      for (int i = 0; i < 4; i++) act_mem[i] = a;
      for (int i = 0; i < 16; i++) w_mem[i] = w;
      for (int i = 0; i < 8; i++) b_mem[i] = b;
   endtask

   function automatic int cnt_we(input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) if (lg_we[i] === 1'b1) n++;
      return n;
   endfunction

   function automatic int cnt_done(input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) if (lg_done[i] === 1'b1) n++;
      return n;
   endfunction

   function automatic int cnt_busy(input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) if (lg_busy[i] === 1'b1) n++;
      return n;
   endfunction

   // Raise start in the current cycle; t is the accept cycle if the engine is idle.
   task automatic start_layer(input logic [1:0] l, output int t);
      @(posedge clk); #2;
      bus.layer        = l;
      bus.start_neuron = 1'b1;
      t = cyc;
   endtask

   // Wait (bounded) for the done pulse; d is the DONE cycle, -1 on timeout.
   task automatic wait_done(input int limit, output int d);
      d = -1;
      for (int i = 0; i < limit; i++) begin
         @(posedge clk); #2;
         if (bus.calculation_done === 1'b1) begin
            d = cyc;
            break;
         end
      end
      chk("done_seen", (d >= 0) ? 32'd1 : 32'd0, 32'd1);
   endtask

   initial begin
      int t;
      int d;
      int t2;
      int d2;

      bus.start_neuron = 1'b0;
      bus.layer        = 2'd0;
      fill(16'h0100, 16'h0080, 16'h0040);

      // Reset state and quiet period.
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      chk("rst_busy", bus.busy, 0);
      chk("rst_we", bus.res_we, 0);
      chk("rst_done", bus.calculation_done, 0);
      chk("rst_waddr", bus.w_addr, 0);
      chk("rst_baddr", bus.b_addr, 0);
      chk("rst_aaddr", bus.act_addr, 0);
      chk("rst_raddr", bus.res_addr, 0);
      chk("rst_rdata", bus.res_data, 0);
      chk("rst_rlayer", bus.res_layer, 0);
      chk("rst_state", state_dbg, ST_IDLE);
      t = cyc;
      repeat (20) @(posedge clk);
      #2;
      chk("rst_quiet_we", cnt_we(t, cyc - 1), 0);
      chk("rst_quiet_busy", cnt_busy(t, cyc - 1), 0);

      // Basic layer 0: 1.0*0.5*4 + 0.25 = 2.25 -> 0x0240.
      start_layer(LAYER_H1, t);
      wait_done(200, d);
      bus.start_neuron = 1'b0;
      @(posedge clk); #2;
      chk("l0_done_cycle", d, t + 15);
      chk("l0_done_count", cnt_done(t, t + 16), 1);
      chk("l0_we_count", cnt_we(t, t + 16), 2);
      chk("l0_we0", lg_we[t + 7], 1);
      chk("l0_data0", lg_rd[t + 7], 16'h0240);
      chk("l0_addr0", lg_ra[t + 7], 0);
      chk("l0_we1", lg_we[t + 14], 1);
      chk("l0_data1", lg_rd[t + 14], 16'h0240);
      chk("l0_addr1", lg_ra[t + 14], 1);
      chk("l0_baddr0", lg_ba[t + 1], 0);
      chk("l0_baddr1", lg_ba[t + 8], 1);
      chk("l0_busy_bias", lg_busy[t + 1], 1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("l0_waddr_n0_%0d", k), lg_wa[t + 2 + k], k);
         chk($sformatf("l0_waddr_n1_%0d", k), lg_wa[t + 9 + k], 4 + k);
      end

      // Activation: bias -1.0, zero weights. ReLU on layer 1, linear on layer 2.
      fill(16'h0100, 16'h0000, 16'hFF00);
      start_layer(LAYER_H2, t);
      wait_done(200, d);
      bus.start_neuron = 1'b0;
      @(posedge clk); #2;
      chk("l1_done_cycle", d, t + 11);
      chk("l1_data0", lg_rd[t + 5], 16'h0000);
      chk("l1_data1", lg_rd[t + 10], 16'h0000);
      chk("l1_we_count", cnt_we(t, t + 12), 2);
      chk("l1_baddr0", lg_ba[t + 1], 2);
      chk("l1_baddr1", lg_ba[t + 6], 3);
      chk("l1_rlayer", lg_rl[t + 5], 1);

      start_layer(LAYER_OUT, t);
      wait_done(200, d);
      bus.start_neuron = 1'b0;
      @(posedge clk); #2;
      chk("l2_done_cycle", d, t + 11);
      chk("l2_we0", lg_we[t + 5], 1);
      chk("l2_data0", lg_rd[t + 5], 16'hFF00);
      chk("l2_data1", lg_rd[t + 10], 16'hFF00);
      chk("l2_baddr0", lg_ba[t + 1], 4);
      chk("l2_baddr1", lg_ba[t + 6], 5);
      chk("l2_waddr0", lg_wa[t + 2], 12);
      chk("l2_waddr3", lg_wa[t + 8], 15);

      // Positive saturation on layer 0.
      fill(16'h7FFF, 16'h7FFF, 16'h7FFF);
      start_layer(LAYER_H1, t);
      wait_done(200, d);
      bus.start_neuron = 1'b0;
      @(posedge clk); #2;
      chk("satp_data0", lg_rd[t + 7], 16'h7FFF);
      chk("satp_data1", lg_rd[t + 14], 16'h7FFF);

      // Negative saturation on layer 2.
      fill(16'h7FFF, 16'h8000, 16'h0000);
      start_layer(LAYER_OUT, t);
      wait_done(200, d);
      bus.start_neuron = 1'b0;
      @(posedge clk); #2;
      chk("satn_data0", lg_rd[t + 5], 16'h8000);
      chk("satn_data1", lg_rd[t + 10], 16'h8000);

      // Back-to-back with start held: layer 0 then layer 1 (0.5*2+0.25 = 0x0140).
      fill(16'h0100, 16'h0080, 16'h0040);
      start_layer(LAYER_H1, t);
      wait_done(200, d);
      @(posedge clk); #2;
      bus.layer = LAYER_H2;
      t2 = cyc;
      wait_done(200, d2);
      bus.start_neuron = 1'b0;
      @(posedge clk); #2;
      chk("b2b_done0", d, t + 15);
      chk("b2b_idle_busy", lg_busy[t2], 0);
      chk("b2b_l1_busy", lg_busy[t2 + 1], 1);
      chk("b2b_l1_baddr", lg_ba[t2 + 1], 2);
      chk("b2b_l1_waddr", lg_wa[t2 + 2], 8);
      chk("b2b_done1", d2, t2 + 11);
      chk("b2b_done_count", cnt_done(t, d2 + 1), 2);
      chk("b2b_we_count", cnt_we(t, d2 + 1), 4);
      chk("b2b_l1_data", lg_rd[t2 + 5], 16'h0140);

      // Layer code 3 with start high is ignored.
      @(posedge clk); #2;
      bus.layer        = LAYER_NONE;
      bus.start_neuron = 1'b1;
      t = cyc;
      repeat (10) @(posedge clk);
      #2;
      chk("l3_state", state_dbg, ST_IDLE);
      chk("l3_busy_count", cnt_busy(t, cyc - 1), 0);
      chk("l3_we_count", cnt_we(t, cyc - 1), 0);
      bus.start_neuron = 1'b0;

      // Reset during MAC aborts the layer.
      start_layer(LAYER_H1, t);
      repeat (3) @(posedge clk);
      #2;
      chk("abort_pre_state", state_dbg, ST_MAC);
      chk("abort_pre_waddr", bus.w_addr, 1);
      rst = 1'b1;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_waddr", bus.w_addr, 0);
      chk("abort_aaddr", bus.act_addr, 0);
      chk("abort_state", state_dbg, ST_IDLE);
      chk("abort_rdata", bus.res_data, 0);
      bus.start_neuron = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      chk("abort_we_count", cnt_we(t + 3, cyc - 1), 0);
      chk("abort_done_count", cnt_done(t + 3, cyc - 1), 0);

      // Clean restart after the abort.
      start_layer(LAYER_H1, t);
      wait_done(200, d);
      bus.start_neuron = 1'b0;
      @(posedge clk); #2;
      chk("restart_done_cycle", d, t + 15);
      chk("restart_data0", lg_rd[t + 7], 16'h0240);
      chk("restart_data1", lg_rd[t + 14], 16'h0240);
      chk("restart_we_count", cnt_we(t, t + 16), 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
